onewire_master: RTL and testbench

//  Byte-level 1-Wire bus master: issues reset/presence, write-byte and read-byte transactions on an

---
 rtl/onewire_master_pkg.sv | 30 +++
 rtl/onewire_sync.sv | 22 ++
 rtl/onewire_master.sv | 143 ++++++++++++++
 tb/tb_onewire_master.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/onewire_master_pkg.sv
// rtl/onewire_master_pkg.sv - shared command codes, FSM states and slot timing defaults
package onewire_master_pkg;

  localparam logic [1:0] CMD_RESET = 2'b00;
  localparam logic [1:0] CMD_WRITE = 2'b01;
  localparam logic [1:0] CMD_READ  = 2'b10;
  localparam logic [1:0] CMD_RSVD  = 2'b11;

  localparam int DEF_CLK_MHZ = 100;
  localparam int DEF_T_RSTL  = 480;
  localparam int DEF_T_PRS   = 70;
  localparam int DEF_T_RSTH  = 480;
  localparam int DEF_T_LOW1  = 6;
  localparam int DEF_T_LOW0  = 60;
  localparam int DEF_T_RDS   = 15;
  localparam int DEF_T_SLOT  = 70;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RST_LOW,
    ST_RST_REL,
    ST_SLOT_LOW,
    ST_SLOT_REL
  } state_t;

  function automatic int us_to_cycles(input int us, input int clk_mhz);
    return us * clk_mhz;
  endfunction

endpackage

// File: rtl/onewire_sync.sv
// rtl/onewire_sync.sv - 2-flop synchronizer for the pad readback, resets to idle-high
module onewire_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Two-stage capture; reset level 1 matches a released, pulled-up line
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/onewire_master.sv
// rtl/onewire_master.sv - byte-level 1-Wire master: bus reset/presence, write byte, read byte
module onewire_master
  import onewire_master_pkg::*;
#(
  parameter int CLK_MHZ = DEF_CLK_MHZ,
  parameter int T_RSTL  = DEF_T_RSTL,
  parameter int T_PRS   = DEF_T_PRS,
  parameter int T_RSTH  = DEF_T_RSTH,
  parameter int T_LOW1  = DEF_T_LOW1,
  parameter int T_LOW0  = DEF_T_LOW0,
  parameter int T_RDS   = DEF_T_RDS,
  parameter int T_SLOT  = DEF_T_SLOT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] cmd,
  input  logic       cmd_valid,
  output logic       ready,
  input  logic [7:0] tx_data,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       presence,
  output logic       presence_valid,
  output logic       done,
  output logic       line_i,
  output logic       line_t,
  input  logic       line_o
);

  localparam int TW = $clog2(us_to_cycles(T_RSTL + T_RSTH, CLK_MHZ));

  // Timer compare points; *_LAST is the final cycle of a state, *_PT a sample point
  localparam logic [TW-1:0] RSTL_LAST = TW'(us_to_cycles(T_RSTL, CLK_MHZ) - 1);
  localparam logic [TW-1:0] RSTH_LAST = TW'(us_to_cycles(T_RSTH, CLK_MHZ) - 1);
  localparam logic [TW-1:0] PRS_PT    = TW'(us_to_cycles(T_PRS, CLK_MHZ));
  localparam logic [TW-1:0] LOW0_LAST = TW'(us_to_cycles(T_LOW0, CLK_MHZ) - 1);
  localparam logic [TW-1:0] LOW1_LAST = TW'(us_to_cycles(T_LOW1, CLK_MHZ) - 1);
  localparam logic [TW-1:0] REL0_LAST = TW'(us_to_cycles(T_SLOT - T_LOW0, CLK_MHZ) - 1);
  localparam logic [TW-1:0] REL1_LAST = TW'(us_to_cycles(T_SLOT - T_LOW1, CLK_MHZ) - 1);
  // Read sample is measured from slot start, but it falls inside SLOT_REL whose timer restarts
  localparam logic [TW-1:0] RDS_PT    = TW'(us_to_cycles(T_RDS - T_LOW1, CLK_MHZ));

  state_t        state, state_n;
  logic [TW-1:0] timer;
  logic [2:0]    bit_cnt;
  logic [1:0]    cmd_q;
  logic [7:0]    data_q;
  logic          line_sync;
  logic          accept;
  logic          write_zero;
  logic [TW-1:0] low_last;
  logic [TW-1:0] rel_last;

  onewire_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (line_o),
    .q   (line_sync)
  );

  assign line_i     = 1'b0;
  // done is registered, so the first IDLE cycle still reports busy
  assign ready      = (state == ST_IDLE) && !done;
  assign accept     = ready && cmd_valid && (cmd != CMD_RSVD);
  assign write_zero = (cmd_q == CMD_WRITE) && !data_q[bit_cnt];
  assign low_last   = write_zero ? LOW0_LAST : LOW1_LAST;
  assign rel_last   = write_zero ? REL0_LAST : REL1_LAST;

  // State register; async reset returns to IDLE, which releases the line at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  // Next-state and line drive
  always_comb begin
    state_n = state;
    line_t  = 1'b1;
    case (state)
      ST_IDLE: begin
        if (accept) state_n = (cmd == CMD_RESET) ? ST_RST_LOW : ST_SLOT_LOW;
      end
      ST_RST_LOW: begin
        line_t = 1'b0;
        if (timer == RSTL_LAST) state_n = ST_RST_REL;
      end
      ST_RST_REL: begin
        if (timer == RSTH_LAST) state_n = ST_IDLE;
      end
      ST_SLOT_LOW: begin
        line_t = 1'b0;
        if (timer == low_last) state_n = ST_SLOT_REL;
      end
      ST_SLOT_REL: begin
        if (timer == rel_last) state_n = (bit_cnt == 3'd7) ? ST_IDLE : ST_SLOT_LOW;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Timer, command capture, sampling and completion pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer          <= '0;
      bit_cnt        <= 3'd0;
      cmd_q          <= CMD_RESET;
      data_q         <= 8'h00;
      rx_data        <= 8'h00;
      rx_valid       <= 1'b0;
      presence       <= 1'b0;
      presence_valid <= 1'b0;
      done           <= 1'b0;
    end else begin
      done           <= 1'b0;
      rx_valid       <= 1'b0;
      presence_valid <= 1'b0;
      timer          <= (state_n != state || state == ST_IDLE) ? '0 : timer + 1'b1;
      if (accept) begin
        cmd_q   <= cmd;
        data_q  <= tx_data;
        bit_cnt <= 3'd0;
      end
      if (state == ST_RST_REL && timer == PRS_PT) presence <= !line_sync;
      if (state == ST_RST_REL && timer == RSTH_LAST) begin
        done           <= 1'b1;
        presence_valid <= 1'b1;
      end
      if (state == ST_SLOT_REL && cmd_q == CMD_READ && timer == RDS_PT)
        data_q[bit_cnt] <= line_sync;
      if (state == ST_SLOT_REL && timer == rel_last) begin
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          done <= 1'b1;
          if (cmd_q == CMD_READ) begin
            rx_data  <= data_q;
            rx_valid <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_onewire_master.sv
// tb/tb_onewire_master.sv - directed bench for onewire_master at CLK_MHZ=1 (1 cycle = 1 us)
module tb_onewire_master;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] cmd = 2'b00;
  logic       cmd_valid = 1'b0;
  logic       ready;
  logic [7:0] tx_data = 8'h00;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       presence;
  logic       presence_valid;
  logic       done;
  logic       line_i;
  logic       line_t;
  logic       line_o;
  logic       slave_low = 1'b0;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int acc = 0;
  int lat;

  // monitor / slave state
  int prev_t = 1;
  int low_run = 0;
  int since_fall = 10000;
  int since_rise = 10000;
  int fall_cnt = 0;
  int done_cnt = 0;
  int rxv_cnt = 0;
  int lows[$];
  int starts[$];
  int slave_mode = 0;   // 0 none, 1 presence responder, 2 read responder
  int rd_base = 0;
  logic [7:0] rd_pat = 8'h00;

  int exp_a5[8] = '{6, 60, 6, 60, 60, 6, 60, 6};
  int exp_0f[8] = '{6, 6, 6, 6, 60, 60, 60, 60};

  // open-drain bus: master release AND slave release, pull-up otherwise
  assign line_o = line_t & !slave_low;

  onewire_master #(.CLK_MHZ(1)) dut (
    .clk            (clk),
    .rst            (rst),
    .cmd            (cmd),
    .cmd_valid      (cmd_valid),
    .ready          (ready),
    .tx_data        (tx_data),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .presence       (presence),
    .presence_valid (presence_valid),
    .done           (done),
    .line_i         (line_i),
    .line_t         (line_t),
    .line_o         (line_o)
  );

  always #5 clk = !clk;

  always @(posedge clk) cyc++;

  // line monitor and slave device model, evaluated away from the active edge
  always @(negedge clk) begin
    int idx;
    if (!line_t && prev_t == 1) begin
      fall_cnt++;
      since_fall = 0;
      low_run = 1;
      starts.push_back(cyc);
    end else if (!line_t) begin
      low_run++;
      since_fall++;
    end else begin
      if (prev_t == 0) begin
        lows.push_back(low_run);
        since_rise = 0;
      end else if (since_rise < 10000) begin
        since_rise++;
      end
      if (since_fall < 10000) since_fall++;
    end
    prev_t = int'(line_t);
    if (done) done_cnt++;
    if (rx_valid) rxv_cnt++;
    idx = fall_cnt - rd_base - 1;
    case (slave_mode)
      1: slave_low = line_t && since_rise >= 30 && since_rise < 150;
      2: slave_low = (idx >= 0 && idx < 8) ? (since_fall < 40 && !rd_pat[idx]) : 1'b0;
      default: slave_low = 1'b0;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic issue(input logic [1:0] c, input logic [7:0] d);
    @(negedge clk);
    cmd = c;
    tx_data = d;
    cmd_valid = 1'b1;
    acc = cyc;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int latency);
    latency = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        latency = cyc - acc;
        break;
      end
    end
  endtask

  function automatic int q_at(input int which, input int i);
    if (which == 0) return (i < lows.size()) ? lows[i] : -1;
    return (i < starts.size()) ? starts[i] : -1;
  endfunction

  initial begin
    int lb, sb, dc, rc, fc;

    // reset state
    #1;
    chk("rst_line_t", line_t, 1);
    chk("rst_line_i", line_i, 0);
    chk("rst_ready", ready, 1);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_flags", {rx_valid, presence, presence_valid, done}, 0);
    @(negedge clk);
    rst = 1'b0;

    // 1: bus reset with a responding slave
    slave_mode = 1;
    lb = lows.size();
    issue(2'b00, 8'h00);
    wait_done(1200, lat);
    chk("t1_latency", lat, 961);
    chk("t1_low_len", q_at(0, lb), 480);
    chk("t1_presence", presence, 1);
    chk("t1_presence_valid", presence_valid, 1);
    chk("t1_ready_at_done", ready, 0);
    @(negedge clk);
    chk("t1_ready_after", ready, 1);
    chk("t1_pv_one_cycle", presence_valid, 0);

    // 2: bus reset, nobody on the bus
    slave_mode = 0;
    issue(2'b00, 8'h00);
    wait_done(1200, lat);
    chk("t2_latency", lat, 961);
    chk("t2_presence", presence, 0);
    chk("t2_presence_valid", presence_valid, 1);
    @(negedge clk);
    chk("t2_ready_after", ready, 1);

    // 3: write 0xA5
    lb = lows.size();
    sb = starts.size();
    rc = rxv_cnt;
    issue(2'b01, 8'hA5);
    wait_done(800, lat);
    chk("t3_latency", lat, 561);
    for (int i = 0; i < 8; i++) chk($sformatf("t3_low_bit%0d", i), q_at(0, lb + i), exp_a5[i]);
    for (int i = 1; i < 8; i++)
      chk($sformatf("t3_slot_gap%0d", i), q_at(1, sb + i) - q_at(1, sb + i - 1), 70);
    chk("t3_no_rx_valid", rxv_cnt - rc, 0);
    @(negedge clk);

    // 4: read 0x3C
    slave_mode = 2;
    rd_pat = 8'h3C;
    rd_base = fall_cnt;
    issue(2'b10, 8'h00);
    wait_done(800, lat);
    chk("t4_latency", lat, 561);
    chk("t4_rx_data", rx_data, 8'h3C);
    chk("t4_rx_valid", rx_valid, 1);
    @(negedge clk);
    chk("t4_rx_valid_pulse", rx_valid, 0);
    slave_mode = 0;

    // 5a: reserved command is refused
    fc = fall_cnt;
    dc = done_cnt;
    @(negedge clk);
    cmd = 2'b11;
    cmd_valid = 1'b1;
    repeat (20) @(negedge clk);
    chk("t5_rsvd_ready", ready, 1);
    chk("t5_rsvd_no_line", fall_cnt - fc, 0);
    chk("t5_rsvd_no_done", done_cnt - dc, 0);
    cmd_valid = 1'b0;

    // 5b: command presented while busy is ignored
    lb = lows.size();
    rc = rxv_cnt;
    issue(2'b01, 8'h0F);
    repeat (100) @(negedge clk);
    cmd = 2'b10;
    tx_data = 8'hFF;
    cmd_valid = 1'b1;
    repeat (200) @(negedge clk);
    cmd_valid = 1'b0;
    wait_done(800, lat);
    chk("t5_latency", lat, 561);
    for (int i = 0; i < 8; i++) chk($sformatf("t5_low_bit%0d", i), q_at(0, lb + i), exp_0f[i]);
    chk("t5_no_rx_valid", rxv_cnt - rc, 0);
    repeat (5) @(negedge clk);
    chk("t5_no_extra_cmd", ready, 1);

    // 6: async reset during bit 3 of a write, then a normal bus reset
    fc = fall_cnt;
    issue(2'b01, 8'h00);
    for (int i = 0; i < 2000 && fall_cnt - fc < 4; i++) @(negedge clk);
    chk("t6_reached_bit3", fall_cnt - fc, 4);
    repeat (10) @(negedge clk);
    dc = done_cnt;
    chk("t6_line_low_before", line_t, 0);
    rst = 1'b1;
    #1;
    chk("t6_line_released", line_t, 1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6_no_done", done_cnt - dc, 0);
    chk("t6_ready", ready, 1);
    slave_mode = 1;
    issue(2'b00, 8'h00);
    wait_done(1200, lat);
    chk("t6_reset_latency", lat, 961);
    chk("t6_presence", presence, 1);
    slave_mode = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
